// File: rtl/fifo_enq_arbiter_if.sv
// Write-side bundle between N_REQ producers, the enqueue arbiter and the FIFO it feeds.
// The arbiter takes the master modport; the producer/FIFO environment takes the slave modport.
interface fifo_enq_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            gnt;
  logic                        fifo_enq;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic                        fifo_deq;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            count;
  logic                        full;
  logic                        locked;

  modport master (
    input  req, req_last, req_data, fifo_deq, fifo_empty,
    output gnt, fifo_enq, fifo_data, count, full, locked
  );

  modport slave (
    output req, req_last, req_data, fifo_deq, fifo_empty,
    input  gnt, fifo_enq, fifo_data, count, full, locked
  );
endinterface

// File: rtl/fifo_enq_arbiter.sv
// Round-robin, packet-locking arbiter for one FIFO write port; keeps its own occupancy count
// because the FIFO only reports empty.
//
// state  | meaning
// S_IDLE | no packet open; round-robin scan from r_last+1 picks the next beat
// S_LOCK | mid-packet; only r_owner may transfer until its last beat
module fifo_enq_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_enq_arbiter_if.master bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      r_last;
  logic [CNT_W-1:0]      r_count;
  logic                  r_enq;
  logic [DATA_WIDTH-1:0] r_data;

  state_t                w_next_state;
  logic [N_REQ-1:0]      w_gnt;
  logic [IDX_W-1:0]      w_sel;
  logic                  w_found;
  logic                  w_can_accept;
  logic                  w_pop;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // No bypass: a pop in this cycle does not make room for a grant in this cycle.
  assign w_can_accept = (r_count < MAX_CNT);
  assign w_pop        = bus.fifo_deq & ~bus.fifo_empty;

  always_comb begin
    w_next_state = r_state;
    w_gnt        = '0;
    w_sel        = r_owner;
    w_found      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_accept) begin
          for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && bus.req[rr_idx(r_last, k)]) begin
              w_found = 1'b1;
              w_sel   = rr_idx(r_last, k);
            end
          end
        end
        if (w_found) begin
          w_gnt[w_sel] = 1'b1;
          if (!bus.req_last[w_sel]) w_next_state = S_LOCK;
        end
      end
      S_LOCK: begin
        if (bus.req[r_owner] && w_can_accept) begin
          w_found        = 1'b1;
          w_gnt[r_owner] = 1'b1;
          if (bus.req_last[r_owner]) w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= LAST_INIT;
      r_count <= '0;
      r_enq   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next_state;
      r_enq   <= w_found;
      if (w_found) begin
        r_data <= bus.req_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
        if (r_state == S_IDLE) begin
          r_last  <= w_sel;
          r_owner <= w_sel;
        end
      end
      case ({w_found, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.fifo_enq  = r_enq;
  assign bus.fifo_data = r_data;
  assign bus.count     = r_count;
  assign bus.full      = (r_count == MAX_CNT);
  assign bus.locked    = (r_state == S_LOCK);
endmodule
